// File: rtl/toy_bpu_filter_pipe.sv
// BPU filter stage: joins a BTFIFO entry with its fetch block, pre-decodes per-slot
// enables/PCs/next-PCs, classifies the last slot for the RAS and issues under fetch-queue credits.
module toy_bpu_filter_pipe #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned FILTER_CHANNEL = 4,
  parameter int unsigned FQ_CREDITS     = 8,
  parameter bit          RAS_EN         = 1'b1,
  localparam int unsigned OFF_W         = $clog2(FILTER_CHANNEL),
  localparam int unsigned CRD_W         = $clog2(FQ_CREDITS + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               bt_vld,
  output logic                               bt_rdy,
  input  logic [ADDR_WIDTH-1:0]              bt_pred_pc,
  input  logic [OFF_W-1:0]                   bt_offset,
  input  logic                               bt_taken,
  input  logic [ADDR_WIDTH-1:0]              bt_tgt_pc,
  input  logic                               rob_vld,
  output logic                               rob_rdy,
  input  logic [32*FILTER_CHANNEL-1:0]       rob_data,
  input  logic                               be_chgflw,
  output logic                               fq_vld,
  output logic [FILTER_CHANNEL-1:0]          fq_en,
  output logic [32*FILTER_CHANNEL-1:0]       fq_inst,
  output logic [ADDR_WIDTH*FILTER_CHANNEL-1:0] fq_pc,
  output logic [ADDR_WIDTH*FILTER_CHANNEL-1:0] fq_pc_nxt,
  output logic                               fq_is_call,
  output logic                               fq_is_ret,
  input  logic                               fq_credit_ret,
  output logic                               ras_req_vld,
  output logic [ADDR_WIDTH-1:0]              ras_req_pc,
  output logic [ADDR_WIDTH-1:0]              ras_req_tgt,
  output logic [1:0]                         ras_req_type,
  output logic                               err_vld
);

  localparam int unsigned IW = 32 * FILTER_CHANNEL;
  localparam int unsigned PW = ADDR_WIDTH * FILTER_CHANNEL;

  logic                  s1_v;
  logic [ADDR_WIDTH-1:0] s1_pred_pc;
  logic [OFF_W-1:0]      s1_offset;
  logic                  s1_taken;
  logic [ADDR_WIDTH-1:0] s1_tgt_pc;
  logic [IW-1:0]         s1_data;

  logic                  s2_v;
  logic [FILTER_CHANNEL-1:0] s2_en;
  logic [IW-1:0]         s2_inst;
  logic [PW-1:0]         s2_pc;
  logic [PW-1:0]         s2_pc_nxt;
  logic                  s2_call;
  logic                  s2_ret;
  logic [ADDR_WIDTH-1:0] s2_last_pc;
  logic [ADDR_WIDTH-1:0] s2_last_nxt;

  logic [CRD_W-1:0]      credits;
  logic                  join_fire;
  logic                  s1_adv;
  logic                  issue;
  logic                  bad;
  logic [OFF_W-1:0]      start;

  logic [FILTER_CHANNEL-1:0] d_en;
  logic [PW-1:0]         d_pc;
  logic [PW-1:0]         d_pc_nxt;
  logic [ADDR_WIDTH-1:0] slot_pc;
  logic [ADDR_WIDTH-1:0] slot_nxt;
  logic [31:0]           last_inst;
  logic [ADDR_WIDTH-1:0] last_pc;
  logic [ADDR_WIDTH-1:0] last_nxt;
  logic                  is_jal;
  logic                  is_jalr;
  logic                  rd_link;
  logic                  rs1_link;
  logic                  d_call;
  logic                  d_ret;
  logic                  unused_pc_lsb;

  assign issue     = s2_v && (credits != '0) && !be_chgflw;
  assign s1_adv    = s1_v && (!s2_v || issue);
  assign bt_rdy    = (!s1_v || s1_adv) && !be_chgflw && !rst;
  assign rob_rdy   = bt_rdy;
  assign join_fire = bt_vld && rob_vld && bt_rdy;

  assign start         = s1_pred_pc[OFF_W+1:2];
  assign bad           = s1_offset < start;
  assign unused_pc_lsb = &{1'b0, s1_pred_pc[1:0]};

  always_comb begin
    d_en      = '0;
    d_pc      = '0;
    d_pc_nxt  = '0;
    slot_pc   = '0;
    slot_nxt  = '0;
    last_inst = '0;
    last_pc   = '0;
    last_nxt  = '0;
    for (int unsigned i = 0; i < FILTER_CHANNEL; i++) begin
      slot_pc  = {s1_pred_pc[ADDR_WIDTH-1:OFF_W+2], OFF_W'(i), 2'b00};
      slot_nxt = (s1_taken && (OFF_W'(i) == s1_offset)) ? s1_tgt_pc : slot_pc + ADDR_WIDTH'(4);
      d_en[i]  = (OFF_W'(i) >= start) && (OFF_W'(i) <= s1_offset);
      d_pc[i*ADDR_WIDTH +: ADDR_WIDTH]     = slot_pc;
      d_pc_nxt[i*ADDR_WIDTH +: ADDR_WIDTH] = slot_nxt;
      if (OFF_W'(i) == s1_offset) begin
        last_inst = s1_data[32*i +: 32];
        last_pc   = slot_pc;
        last_nxt  = slot_nxt;
      end
    end
  end

  // Link-register convention: x1/x5. A link write takes precedence, so ret excludes call.
  assign is_jal   = last_inst[6:0] == 7'b1101111;
  assign is_jalr  = (last_inst[6:0] == 7'b1100111) && (last_inst[14:12] == 3'b000);
  assign rd_link  = (last_inst[11:7] == 5'd1) || (last_inst[11:7] == 5'd5);
  assign rs1_link = (last_inst[19:15] == 5'd1) || (last_inst[19:15] == 5'd5);
  assign d_call   = RAS_EN && (is_jal || is_jalr) && rd_link;
  assign d_ret    = RAS_EN && is_jalr && rs1_link && (last_inst[19:15] != last_inst[11:7])
                    && (last_inst[31:20] == 12'h000) && !d_call;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      err_vld <= 1'b0;
      credits <= CRD_W'(FQ_CREDITS);
    end else begin
      err_vld <= s1_adv && bad && !be_chgflw;
      if (be_chgflw) begin
        s1_v <= 1'b0;
        s2_v <= 1'b0;
      end else begin
        if (join_fire)   s1_v <= 1'b1;
        else if (s1_adv) s1_v <= 1'b0;
        if (s1_adv && !bad) s2_v <= 1'b1;
        else if (issue)     s2_v <= 1'b0;
      end
      case ({issue, fq_credit_ret})
        2'b10:   credits <= credits - CRD_W'(1);
        2'b01:   if (credits != CRD_W'(FQ_CREDITS)) credits <= credits + CRD_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (join_fire) begin
      s1_pred_pc <= bt_pred_pc;
      s1_offset  <= bt_offset;
      s1_taken   <= bt_taken;
      s1_tgt_pc  <= bt_tgt_pc;
      s1_data    <= rob_data;
    end
    if (s1_adv && !bad) begin
      s2_en       <= d_en;
      s2_inst     <= s1_data;
      s2_pc       <= d_pc;
      s2_pc_nxt   <= d_pc_nxt;
      s2_call     <= d_call;
      s2_ret      <= d_ret;
      s2_last_pc  <= last_pc;
      s2_last_nxt <= last_nxt;
    end
  end

  assign fq_vld       = issue;
  assign fq_en        = s2_en;
  assign fq_inst      = s2_inst;
  assign fq_pc        = s2_pc;
  assign fq_pc_nxt    = s2_pc_nxt;
  assign fq_is_call   = s2_call;
  assign fq_is_ret    = s2_ret;
  assign ras_req_vld  = issue && (s2_call || s2_ret);
  assign ras_req_pc   = s2_last_pc;
  assign ras_req_tgt  = s2_last_nxt;
  assign ras_req_type = {s2_ret, s2_call};

endmodule

// File: doc/toy_bpu_filter_pipe.md
# toy_bpu_filter_pipe

Pipelined, parametrised successor to the BPU filter stage. It joins a branch-target FIFO entry with its fetched instruction block, registers the pair, and pre-decodes per-slot enables, PCs and next-PCs. It classifies the terminating instruction as call or return for the RAS and issues to the fetch queue under a credit counter instead of a combinational ready. It sits between the BTFIFO/ROB outputs and the fetch queue, and is flushed by backend change-of-flow.

## Interface
- ADDR_WIDTH, 32, PC width.
- FILTER_CHANNEL, 4, 32-bit instruction slots per fetch block (power of 2, 2..16); block is FILTER_CHANNEL*4 bytes aligned.
- FQ_CREDITS, 8, fetch-queue entries; credit counter width $clog2(FQ_CREDITS+1).
- RAS_EN, 1, 0 forces is_call/is_ret to 0 and ras_req_vld to 0.
- OFF_W, derived $clog2(FILTER_CHANNEL), slot-index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- bt_vld / bt_rdy  in/out  1  BTFIFO handshake.
- bt_pred_pc  in  ADDR_WIDTH  fetch PC of block.
- bt_offset  in  OFF_W  slot index of last instruction in block.
- bt_taken  in  1  last slot predicted taken.
- bt_tgt_pc  in  ADDR_WIDTH  predicted target.
- rob_vld / rob_rdy  in/out  1  fetch-data handshake.
- rob_data  in  32*FILTER_CHANNEL  slot i at bits [32i+31:32i].
- be_chgflw  in  1  flush pulse.
- fq_vld  out  1  block issued this cycle (single-cycle, no ready).
- fq_en  out  FILTER_CHANNEL  per-slot valid mask.
- fq_inst  out  32*FILTER_CHANNEL  slot instructions.
- fq_pc  out  ADDR_WIDTH*FILTER_CHANNEL  slot PCs.
- fq_pc_nxt  out  ADDR_WIDTH*FILTER_CHANNEL  slot next-PCs.
- fq_is_call, fq_is_ret  out  1  classification of last slot.
- fq_credit_ret  in  1  one fetch-queue entry freed.
- ras_req_vld  out  1  pulse with fq_vld when call or ret.
- ras_req_pc, ras_req_tgt  out  ADDR_WIDTH  last-slot PC, its next-PC.
- ras_req_type  out  2  {is_ret, is_call}.
- err_vld  out  1  malformed block dropped.

## Operation
- Join: transfer when bt_vld && rob_vld && bt_rdy; bt_rdy == rob_rdy == (!s1_v || s1_adv) && !be_chgflw && !rst. Neither side is consumed alone.
- S1 register: raw pair. s1_adv = s1_v && (!s2_v || issue).
- S2 register: decoded result. issue = s2_v && credits != 0 && !be_chgflw; fq_vld = issue.
- Decode in S1->S2: start = pred_pc[OFF_W+1:2]; en[i] = (i >= start) && (i <= offset); pc[i] = {pred_pc[AW-1:OFF_W+2], i, 2'b00}; pc_nxt[i] = pc[i]+4, except slot offset when taken: tgt_pc. Disabled slots carry computed pc, en=0.
- offset < start: block does not enter S2, err_vld pulses for 1 cycle when S1 advances, no credit used.
- Call (last slot): jalr with funct3=0, or jal, with rd ∈ {x1,x5}. Ret: jalr funct3=0, rs1 ∈ {x1,x5}, rs1 != rd, imm=0. Both may not be set; call wins. RVC not decoded.
- Credits: reset to FQ_CREDITS; −1 on issue, +1 on fq_credit_ret; both same cycle net 0; ret at FQ_CREDITS saturates (no wrap).
- Flush: be_chgflw clears s1_v and s2_v at the clock edge, blocks join and issue that cycle; credits unchanged.

## Timing
- Reset: s1_v, s2_v, fq_vld, ras_req_vld, err_vld = 0; credits = FQ_CREDITS; bt_rdy/rob_rdy = 0 while rst high, 1 the cycle after.
- Latency: join at cycle N -> fq_vld at N+2 when credits available. Throughput 1 block/cycle.
- Zero credits: S2 holds, S1 fills, then bt_rdy drops; issue resumes the cycle after credit_ret (credits become 1).
- fq_*, ras_* outputs are S2-registered; valid only with fq_vld. ras_req_vld = fq_vld && RAS_EN && (call||ret).
- Flush and join in the same cycle: join is suppressed (rdy=0), so nothing is lost.

## Test plan
- FC=4: pred_pc=0x1008, offset=3, taken, tgt=0x2000, jal rd=x1 in slot 3 -> 2 cycles later fq_vld, fq_en=4'b1100, pc{0x1008,0x100C}, pc_nxt[3]=0x2000, ras_req_type=2'b01, ras_req_pc=0x100C.
- jalr x0,0(x1) in slot 1, pred_pc=0x3000, offset=1, not taken -> fq_en=4'b0011, fq_is_ret=1, pc_nxt[1]=0x3008.
- FQ_CREDITS=2, no credit_ret, 4 blocks back-to-back -> 2 issue, bt_rdy low after S1/S2 full; one credit_ret -> block 3 issues next cycle.
- be_chgflw with S1 and S2 full -> no fq_vld that or next cycles, credits unchanged, bt_rdy high next cycle.
- pred_pc=0x100C, offset=1 -> err_vld 1 cycle, no fq_vld, credits unchanged.
- issue and credit_ret same cycle at credits=1 -> credits stay 1; credit_ret at FQ_CREDITS -> stays FQ_CREDITS.
